// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for the stopwatch.
// Scans BCD digits onto shared cathodes and blinks the adjusted digit pair.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] led_0,
    input  logic [3:0] led_1,
    input  logic [3:0] led_2,
    input  logic [3:0] led_3,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        POS_SEC_LO = 2'd0,
        POS_SEC_HI = 2'd1,
        POS_MIN_LO = 2'd2,
        POS_MIN_HI = 2'd3
    } pos_t;

    logic [RW-1:0] rcnt;
    pos_t          idx;
    logic [BW-1:0] bcnt;
    logic          blink;

    logic [3:0] digit;
    logic [6:0] glyph;
    logic       in_pair;
    logic       blank;
    logic [3:0] an_d;
    logic [7:0] seg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= POS_SEC_LO;
        end else if (rcnt == R_LAST) begin
            rcnt <= '0;
            idx  <= pos_t'(idx + 2'd1);
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // Held at zero outside adjust so every adjust entry opens with a visible half-period.
    always_ff @(posedge clk) begin
        if (rst || !adj) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (bcnt == B_LAST) begin
            bcnt  <= '0;
            blink <= ~blink;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    always_comb begin
        digit = led_0;
        case (idx)
            POS_SEC_LO: digit = led_0;
            POS_SEC_HI: digit = led_1;
            POS_MIN_LO: digit = led_2;
            POS_MIN_HI: digit = led_3;
            default:    digit = led_0;
        endcase
    end

    always_comb begin
        glyph = 7'b1111111;
        case (digit)
            4'd0: glyph = 7'b1000000;
            4'd1: glyph = 7'b1111001;
            4'd2: glyph = 7'b0100100;
            4'd3: glyph = 7'b0110000;
            4'd4: glyph = 7'b0011001;
            4'd5: glyph = 7'b0010010;
            4'd6: glyph = 7'b0000010;
            4'd7: glyph = 7'b1111000;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    end

    // Anode stays enabled on a blanked position so scan timing is unchanged.
    always_comb begin
        in_pair = sel ? (idx == POS_SEC_LO || idx == POS_SEC_HI)
                      : (idx == POS_MIN_LO || idx == POS_MIN_HI);
        blank   = adj && blink && in_pair;
        an_d    = ~(4'b0001 << idx);
        seg_d   = blank ? 8'hFF : {(idx != POS_MIN_LO), glyph};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= '1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: arithmetic scan/blink model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_seg7_scan_driver;

    localparam int R = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] led_0 = '0;
    logic [3:0] led_1 = '0;
    logic [3:0] led_2 = '0;
    logic [3:0] led_3 = '0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .REFRESH_DIV(R),
        .BLINK_DIV  (B)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .led_0(led_0),
        .led_1(led_1),
        .led_2(led_2),
        .led_3(led_3),
        .adj  (adj),
        .sel  (sel),
        .seg  (seg),
        .an   (an)
    );

    // Model: position from cycles since reset, blink phase from cycles since adj rose.
    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };
    int         t = 0;
    int         k = 0;
    int         pos;
    bit         valid = 0;
    bit         bl;
    logic [3:0] d;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_an  = 4'b1111;
            exp_seg = 8'hFF;
            t = 0;
            k = 0;
            valid = 1;
        end else begin
            pos = (t / R) % 4;
            bl  = adj && (((k / B) % 2) == 1) && (sel ? (pos < 2) : (pos >= 2));
            d   = (pos == 0) ? led_0 : (pos == 1) ? led_1 : (pos == 2) ? led_2 : led_3;
            exp_an  = ~(4'b0001 << pos);
            exp_seg = bl ? 8'hFF : {(pos != 2), glyph_tab[d]};
            t = t + 1;
            k = adj ? k + 1 : 0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (valid) begin
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL model @%0t: an=%b seg=%h expected an=%b seg=%h",
                         $time, an, seg, exp_an, exp_seg);
            end
        end
    end

    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg_tab [4] = '{8'hC0, 8'hF9, 8'h24, 8'hB0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        led_3 = d3;
        led_2 = d2;
        led_1 = d1;
        led_0 = d0;
    endtask

    task automatic lit(input string name, input logic [3:0] ea, input logic [7:0] es);
        checks++;
        if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL %s @%0t: an=%b seg=%h expected an=%b seg=%h",
                     name, $time, an, seg, ea, es);
        end
    endtask

    initial begin
        // Basic scan, then invalid BCD codes
        set_digits(4'd3, 4'd2, 4'd1, 4'd0);
        do_reset;
        lit("reset_state", 4'b1111, 8'hFF);
        for (int n = 0; n < 48; n++) begin
            if (n == 16) led_1 = 4'hA;
            if (n == 32) begin
                led_1 = 4'hF;
                led_3 = 4'hC;
            end
            tick;
            if (n < 16) lit("basic_scan", an_tab[n / 4], seg_tab[n / 4]);
            if (n == 16) lit("bad_bcd_pos0", 4'b1110, 8'hC0);
            if (n == 20 || n == 23) lit("bad_bcd_A", 4'b1101, 8'hFF);
            if (n == 24 || n == 40) lit("bad_bcd_pos2", 4'b1011, 8'h24);
            if (n == 44) lit("bad_bcd_C", 4'b0111, 8'hFF);
        end

        // Seconds blink, adj rises at edge 4
        set_digits(4'd3, 4'd2, 4'd1, 4'd0);
        adj = 1'b0;
        sel = 1'b1;
        do_reset;
        for (int n = 0; n < 40; n++) begin
            if (n == 4) adj = 1'b1;
            tick;
            if (n == 3) lit("sec_pre", 4'b1110, 8'hC0);
            if (n == 12 || n == 28) lit("sec_min_visible", 4'b0111, 8'hB0);
            if (n >= 16 && n <= 19) lit("sec_blank", 4'b1110, 8'hFF);
            if (n == 20) lit("sec_visible", 4'b1101, 8'hF9);
            if (n == 32) lit("sec_blank2", 4'b1110, 8'hFF);
        end

        // Minutes blink from release, with sel toggles mid-blank
        adj = 1'b1;
        sel = 1'b0;
        do_reset;
        for (int n = 0; n < 48; n++) begin
            if (n == 26) sel = 1'b1;
            if (n == 40) sel = 1'b0;
            tick;
            if (n == 7) lit("min_sec_visible", 4'b1101, 8'hF9);
            if (n == 8 || n == 24 || n == 40) lit("min_blank_dp", 4'b1011, 8'hFF);
            if (n == 12) lit("min_blank_hi", 4'b0111, 8'hFF);
            if (n == 16) lit("min_sec_visible2", 4'b1110, 8'hC0);
            if (n == 26) lit("sel_move", 4'b1011, 8'h24);
            if (n == 28) lit("sel_move_hi", 4'b0111, 8'hB0);
        end

        // Reset mid-slot while blanking, then adjust exit during blank
        adj = 1'b1;
        sel = 1'b0;
        do_reset;
        for (int n = 0; n < 9; n++) begin
            tick;
            if (n == 8) lit("pre_rst_blank", 4'b1011, 8'hFF);
        end
        rst = 1'b1;
        tick;
        lit("mid_rst", 4'b1111, 8'hFF);
        rst = 1'b0;
        tick;
        lit("post_rst", 4'b1110, 8'hC0);
        for (int n = 1; n < 9; n++) begin
            tick;
            if (n == 8) lit("blank_before_exit", 4'b1011, 8'hFF);
        end
        adj = 1'b0;
        tick;
        lit("adj_exit", 4'b1011, 8'h24);
        for (int n = 0; n < 20; n++) tick;

        // Live update mid-slot
        set_digits(4'd3, 4'd2, 4'd1, 4'd4);
        do_reset;
        tick;
        lit("live_4", 4'b1110, 8'h99);
        tick;
        lit("live_4b", 4'b1110, 8'h99);
        led_0 = 4'd5;
        tick;
        lit("live_5", 4'b1110, 8'h92);
        tick;
        lit("live_5b", 4'b1110, 8'h92);
        tick;
        lit("live_next", 4'b1101, 8'hF9);

        // Remaining glyphs
        set_digits(4'd6, 4'd7, 4'd8, 4'd9);
        do_reset;
        for (int n = 0; n < 16; n++) begin
            tick;
            if (n == 0) lit("glyph9", 4'b1110, 8'h90);
            if (n == 4) lit("glyph8", 4'b1101, 8'h80);
            if (n == 8) lit("glyph7", 4'b1011, 8'h78);
            if (n == 12) lit("glyph6", 4'b0111, 8'h82);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
